// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA; copies LENGTH bytes from {src,8'h00} to DEST_BASE.
// Optional feature: OAM_DMA_ECHO_FOLD_EN folds echo-RAM source pages E0..FF onto C0..DF.
`default_nettype none

module oam_dma #(
  parameter int          LENGTH    = 160,
  parameter logic [15:0] DEST_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWrite,
  input  logic [7:0]  regData,
  output logic [7:0]  regDataOut,
  output logic        busRequest,
  output logic [15:0] memAddress,
  input  logic [7:0]  memDataR,
  output logic [7:0]  memDataW,
  output logic        RW,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  localparam logic [7:0] LAST = 8'(LENGTH - 1);

  state_t     state;
  logic [7:0] src;
  logic [7:0] index;
  logic [7:0] index_nx;
  logic [7:0] src_rd;

  assign index_nx   = index + 8'd1;
  assign regDataOut = src;

`ifdef OAM_DMA_ECHO_FOLD_EN
  // E0..FF mirrors C0..DF; clearing bit 5 of the page is the same as subtracting 8'h20
  assign src_rd = (src[7:5] == 3'b111) ? {3'b110, src[4:0]} : src;
`else
  assign src_rd = src;
`endif

  // Memory is registered, so read data arrives exactly in the WRITE cycle
  assign memDataW = (state == WRITE) ? memDataR : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      src        <= 8'h00;
      index      <= 8'h00;
      busRequest <= 1'b0;
      memAddress <= 16'h0000;
      RW         <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (regWrite) begin
        state      <= START;
        src        <= regData;
        index      <= 8'h00;
        busRequest <= 1'b1;
        memAddress <= 16'h0000;
        RW         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busRequest <= 1'b0;
            memAddress <= 16'h0000;
            RW         <= 1'b0;
          end
          START: begin
            state      <= READ;
            memAddress <= {src_rd, index};
            RW         <= 1'b0;
          end
          READ: begin
            state      <= WRITE;
            memAddress <= DEST_BASE + {8'h00, index};
            RW         <= 1'b1;
          end
          WRITE: begin
            if (index == LAST) begin
              state      <= IDLE;
              index      <= 8'h00;
              busRequest <= 1'b0;
              memAddress <= 16'h0000;
              RW         <= 1'b0;
              done       <= 1'b1;
            end else begin
              state      <= READ;
              index      <= index_nx;
              memAddress <= {src_rd, index_nx};
              RW         <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench; stimulus queues expected copies, a negedge monitor checks them.
`default_nettype none

module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regWrite = 1'b0;
  logic [7:0]  regData = 8'h00;
  logic [7:0]  regDataOut;
  logic        busRequest;
  logic [15:0] memAddress;
  logic [7:0]  memDataR = 8'h00;
  logic [7:0]  memDataW;
  logic        RW;
  logic        done;

  logic        regWrite1 = 1'b0;
  logic [7:0]  regData1 = 8'h00;
  logic [7:0]  regDataOut1;
  logic        busRequest1;
  logic [15:0] memAddress1;
  logic [7:0]  memDataR1 = 8'h00;
  logic [7:0]  memDataW1;
  logic        RW1;
  logic        done1;

  oam_dma u_dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .regData(regData),
    .regDataOut(regDataOut), .busRequest(busRequest), .memAddress(memAddress),
    .memDataR(memDataR), .memDataW(memDataW), .RW(RW), .done(done)
  );

  oam_dma #(.LENGTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .regWrite(regWrite1), .regData(regData1),
    .regDataOut(regDataOut1), .busRequest(busRequest1), .memAddress(memAddress1),
    .memDataR(memDataR1), .memDataW(memDataW1), .RW(RW1), .done(done1)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] ra;
    logic [15:0] wa;
    logic [7:0]  wd;
  } ev_t;

  ev_t exp_q[$];
  int  done_q[$];

  function automatic logic [7:0] memval(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h9A;
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_FOLD_EN
    return (s >= 8'hE0) ? s - 8'h20 : s;
`else
    return s;
`endif
  endfunction

  // Registered memory models: data valid one cycle after the address
  always @(posedge clk) begin
    memDataR  <= memval(memAddress);
    memDataR1 <= memval(memAddress1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_events(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      ev_t e;
      e.ra = {fold(s), 8'(i)};
      e.wa = 16'hFE00 + 16'(i);
      e.wd = memval(e.ra);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [7:0] d, output int t);
    regWrite = 1'b1;
    regData  = d;
    t        = cyc;
    @(negedge clk);
    regWrite = 1'b0;
  endtask

  logic [15:0] prev_addr = 16'h0000;

  always @(negedge clk) begin
    if (rst && busRequest && RW) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none (cycle %0d)", memAddress, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("read_addr", prev_addr, e.ra);
        chk("write_addr", memAddress, e.wa);
        chk("write_data", memDataW, e.wd);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
      chk("busreq_at_done", busRequest, 1'b0);
    end
    prev_addr = memAddress;
  end

  initial begin
    int t0;
    int t1;

    // Reset held two cycles with regWrite asserted
    rst      = 1'b0;
    regWrite = 1'b1;
    regData  = 8'hAA;
    regWrite1 = 1'b1;
    regData1  = 8'h55;
    repeat (2) @(negedge clk);
    chk("rst_busreq", busRequest, 1'b0);
    chk("rst_rw", RW, 1'b0);
    chk("rst_addr", memAddress, 16'h0000);
    chk("rst_wdata", memDataW, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_regout", regDataOut, 8'h00);
    chk("rst_regout1", regDataOut1, 8'h00);
    regWrite  = 1'b0;
    regWrite1 = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busreq", busRequest, 1'b0);

    // LENGTH=1 instance
    regWrite1 = 1'b1;
    regData1  = 8'h80;
    t0 = cyc;
    @(negedge clk);
    regWrite1 = 1'b0;
    chk("l1_start_busreq", busRequest1, 1'b1);
    @(negedge clk);
    chk("l1_read_addr", memAddress1, 16'h8000);
    chk("l1_read_rw", RW1, 1'b0);
    @(negedge clk);
    chk("l1_write_addr", memAddress1, 16'hFE00);
    chk("l1_write_rw", RW1, 1'b1);
    chk("l1_write_data", memDataW1, 8'h1A);
    @(negedge clk);
    chk("l1_done_cycle", cyc - t0, 4);
    chk("l1_done", done1, 1'b1);
    chk("l1_busreq_off", busRequest1, 1'b0);
    @(negedge clk);
    chk("l1_done_pulse", done1, 1'b0);
    chk("l1_regout", regDataOut1, 8'h80);

    // Full copy from C000
    push_events(8'hC0, 160);
    issue(8'hC0, t0);
    done_q.push_back(t0 + 322);
    chk("full_busreq_c1", busRequest, 1'b1);
    chk("full_rw_c1", RW, 1'b0);
    chk("full_regout", regDataOut, 8'hC0);
    repeat (330) @(negedge clk);
    chk("full_q_empty", exp_q.size(), 0);

    // Restart after 10 bytes with a new source page
    push_events(8'hC0, 10);
    issue(8'hC0, t0);
    repeat (21) @(negedge clk);
    issue(8'hC1, t1);
    push_events(8'hC1, 160);
    done_q.push_back(t1 + 322);
    repeat (330) @(negedge clk);
    chk("restart_regout", regDataOut, 8'hC1);
    chk("restart_q_empty", exp_q.size(), 0);

    // Reset taking effect where byte 50's WRITE would begin
    push_events(8'hC0, 50);
    issue(8'hC0, t0);
    repeat (101) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rw", RW, 1'b0);
    chk("midrst_busreq", busRequest, 1'b0);
    chk("midrst_addr", memAddress, 16'h0000);
    chk("midrst_done", done, 1'b0);
    chk("midrst_q_empty", exp_q.size(), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_q.size(), 0);
    push_events(8'hC0, 160);
    issue(8'hC0, t0);
    done_q.push_back(t0 + 322);
    repeat (330) @(negedge clk);
    chk("postrst_q_empty", exp_q.size(), 0);

    // Echo-RAM source page
    push_events(8'hE0, 160);
    issue(8'hE0, t0);
    done_q.push_back(t0 + 322);
    repeat (330) @(negedge clk);
    chk("echo_regout", regDataOut, 8'hE0);
    chk("echo_q_empty", exp_q.size(), 0);
    chk("final_done_q_empty", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter LENGTH, default 160, number of bytes copied per transfer (1..256).
REQ-002 Parameter DEST_BASE, default 16'hFE00, destination address of byte 0.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 regWrite  input  1  one-cycle strobe; CPU write to the DMA register (FF46).
REQ-006 regData  input  8  source high byte, sampled when regWrite=1.
REQ-007 regDataOut  output  8  last value written to the DMA register.
REQ-008 busRequest  output  1  high while DMA owns the memory bus; arbiter routes memAddress/RW/memDataW over the CPU's.
REQ-009 memAddress  output  16  bus address driven by DMA.
REQ-010 memDataR  input  8  read data, valid one clk after the address is presented (registered memory).
REQ-011 memDataW  output  8  write data.
REQ-012 RW  output  1  1 => WRITE, 0 => READ.
REQ-013 done  output  1  one-cycle pulse after the last byte is written.

Function
REQ-014 States: IDLE, START, READ, WRITE.
REQ-015 IDLE: busRequest=0, RW=0; regWrite -> latch regData into regDataOut and source register, index=0, go START.
REQ-016 START: one-cycle bus-handover delay, busRequest=1, RW=0, then READ.
REQ-017 READ: memAddress={src,8'h00}+index, RW=0, then WRITE.
REQ-018 WRITE: memAddress=DEST_BASE+index, RW=1, memDataW=memDataR; if index==LENGTH-1 go IDLE and pulse done next cycle, else index+1 and go READ.
REQ-019 Transfer latency: regWrite in cycle 0 -> first READ in cycle 2 -> last WRITE in cycle 2*LENGTH+1 -> done=1 in cycle 2*LENGTH+2, busRequest=0 from that cycle.
REQ-020 index is 8 bits; source address low byte = index, no carry into the high byte.
REQ-021 busRequest=1 in START, READ, WRITE only; memAddress=0 and memDataW=0 in IDLE.
REQ-022 regWrite while not IDLE: update regDataOut/source, index=0, go START (restart); no done pulse for the aborted transfer.
REQ-023 regWrite in the same cycle as the final WRITE: restart wins, no done pulse.
REQ-024 regDataOut readable at any time; value unchanged by transfer progress.

Reset
REQ-025 rst=0 at a posedge: state=IDLE, index=0, regDataOut=8'h00, busRequest=0, RW=0, memAddress=0, memDataW=0, done=0.
REQ-026 Reset mid-transfer aborts immediately; no write issued in the reset cycle, no done pulse.
REQ-027 regWrite ignored while rst=0.

Configuration
REQ-028 Macro OAM_DMA_ECHO_FOLD_EN defined: source high byte 8'hE0..8'hFF folded to 8'hC0..8'hDF (subtract 8'h20) for READ addresses; regDataOut keeps the unfolded value.
REQ-029 Macro OAM_DMA_ECHO_FOLD_EN undefined: source high byte used unmodified for all values.

Verification
REQ-030 Reset: rst=0 two cycles with regWrite=1 -> all outputs 0, state IDLE, regDataOut=8'h00.
REQ-031 Full copy: memory model C000..C09F = index^8'h5A, regWrite regData=8'hC0 -> 160 writes FE00..FE9F with matching data, RW alternates 0/1, done high exactly in cycle 322, busRequest high cycles 1..321.
REQ-032 Restart: regData=8'hC0, after 10 bytes regWrite regData=8'hC1 -> writes restart at FE00 reading C100, exactly one done pulse, regDataOut=8'hC1.
REQ-033 Reset mid-operation: rst=0 during WRITE of byte 50 -> no RW=1 in reset cycle, busRequest=0, no done; subsequent regWrite performs a full 160-byte transfer.
REQ-034 Echo source: regData=8'hE0 -> with OAM_DMA_ECHO_FOLD_EN reads C000..C09F; without it reads E000..E09F; regDataOut=8'hE0 in both builds.
REQ-035 LENGTH=1 instance: regWrite regData=8'h80 -> one read 8000, one write FE00, done in cycle 4.
